// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, machine word and the memory arbiter FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of consecutive data grants made while instruction fetch waits.
// Only exists when ARB_FAIRNESS_EN is defined.
`ifdef ARB_FAIRNESS_EN
module arb_fair_cnt #(
    parameter int STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == CNT_W'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory; data has priority.
// Define ARB_FAIRNESS_EN to force an instruction grant after STARVE_MAX data grants.
//
// state | meaning
// IDLE  | no RAM access, arbitrate pending requests
// IACC  | instruction read in flight
// DACC  | data read or write in flight
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    arb_state_t state_q, state_d;
    logic       data_req;
    logic       starve;
    logic       ram_done;

    assign data_req = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);

`ifdef ARB_FAIRNESS_EN
    logic at_max;
    logic dacc_grant;
    logic iacc_grant;

    assign dacc_grant = (state_q == IDLE) && (state_d == DACC);
    assign iacc_grant = (state_q == IDLE) && (state_d == IACC);

    arb_fair_cnt #(.STARVE_MAX(STARVE_MAX)) u_fair_cnt (
        .CLK    (CLK),
        .RST    (RST),
        .inc    (dacc_grant & iREN),
        .clr    (iacc_grant | (dacc_grant & ~iREN)),
        .at_max (at_max)
    );

    assign starve = at_max & iREN;
`else
    // Strict priority; the parameter is kept only for interface compatibility.
    assign starve = 1'b0 && (STARVE_MAX != 0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IDLE: begin
                if (data_req && !starve) begin
                    state_d = DACC;
                end else if (iREN) begin
                    state_d = IACC;
                end
            end
            IACC: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN || ram_done) begin
                    state_d = IDLE;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!data_req || ram_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait tracks the request itself; only a granted ACCESS releases it.
    assign iwait = iREN & ~((state_q == IACC) && (ramstate == ACCESS));
    assign dwait = data_req & ~((state_q == DACC) && (ramstate == ACCESS));

    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level owner model plus directed literal checks.
// Fairness expectations follow ARB_FAIRNESS_EN.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [DW-1:0] iload;
    logic          dREN;
    logic          dWEN;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dstore;
    logic          dwait;
    logic [DW-1:0] dload;
    logic          ramREN;
    logic          ramWEN;
    logic [AW-1:0] ramaddr;
    logic [DW-1:0] ramstore;
    logic [DW-1:0] ramload;
    ramstate_t     ramstate;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who currently owns the RAM, and how many data grants skipped a waiting fetch.
    typedef enum int {M_NONE, M_INSTR, M_DATA} owner_t;
    owner_t owner = M_NONE;
    int     skipped = 0;
    bit     model_live = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            owner   = M_NONE;
            skipped = 0;
        end else begin
            case (owner)
                M_NONE: begin
                    if ((dREN || dWEN) && !(FAIR && iREN && skipped == SM)) begin
                        owner   = M_DATA;
                        skipped = iREN ? ((skipped < SM) ? skipped + 1 : SM) : 0;
                    end else if (iREN) begin
                        owner   = M_INSTR;
                        skipped = 0;
                    end
                end
                M_INSTR: if (!iREN || ramstate == ACCESS || ramstate == ERROR) owner = M_NONE;
                M_DATA:  if (!(dREN || dWEN) || ramstate == ACCESS || ramstate == ERROR) owner = M_NONE;
                default: owner = M_NONE;
            endcase
        end
        model_live = 1'b1;
    end

    always @(negedge CLK) begin
        if (model_live) begin
            logic          e_ren, e_wen, e_iw, e_dw;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_store;
            e_ren   = 1'b0;
            e_wen   = 1'b0;
            e_addr  = '0;
            e_store = '0;
            if (owner == M_INSTR) begin
                e_ren  = iREN;
                e_addr = iaddr;
            end else if (owner == M_DATA) begin
                e_wen   = dWEN;
                e_ren   = dREN && !dWEN;
                e_addr  = daddr;
                e_store = dstore;
            end
            e_iw = iREN && !(owner == M_INSTR && ramstate == ACCESS);
            e_dw = (dREN || dWEN) && !(owner == M_DATA && ramstate == ACCESS);
            chk("m_ramREN", ramREN, e_ren);
            chk("m_ramWEN", ramWEN, e_wen);
            chk("m_ramaddr", ramaddr, e_addr);
            chk("m_ramstore", ramstore, e_store);
            chk("m_iwait", iwait, e_iw);
            chk("m_dwait", dwait, e_dw);
            if (owner == M_INSTR && ramstate == ACCESS) chk("m_iload", iload, ramload);
            if (owner == M_DATA && ramstate == ACCESS) chk("m_dload", dload, ramload);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] grants[$];

    initial begin
        RST = 1'b1; iREN = 1'b1; iaddr = 32'h0000_0040;
        dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
        ramstate = FREE; ramload = '0;

        // Reset held with a pending fetch
        cyc(); #2;
        chk("rst_ramREN", ramREN, 1'b0);
        chk("rst_ramWEN", ramWEN, 1'b0);
        chk("rst_iwait", iwait, 1'b1);
        cyc(); #2;
        chk("rst2_ramREN", ramREN, 1'b0);
        cyc(); RST = 1'b0; #2;
        chk("rst_arb_cycle_ramREN", ramREN, 1'b0);

        // Instruction fetch, 2 BUSY then ACCESS
        cyc(); ramstate = BUSY; #2;
        chk("if_ramREN", ramREN, 1'b1);
        chk("if_ramaddr", ramaddr, 32'h0000_0040);
        chk("if_iwait_busy", iwait, 1'b1);
        cyc(); #2;
        chk("if_iwait_busy2", iwait, 1'b1);
        cyc(); ramstate = ACCESS; ramload = 32'h2408_0001; #2;
        chk("if_iwait_done", iwait, 1'b0);
        chk("if_iload", iload, 32'h2408_0001);
        cyc(); iREN = 1'b0; ramstate = FREE; #2;
        chk("if_back_idle", ramREN, 1'b0);

        // Simultaneous instruction read and data write
        cyc(); iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; #2;
        chk("sim_arb_ramWEN", ramWEN, 1'b0);
        chk("sim_arb_iwait", iwait, 1'b1);
        chk("sim_arb_dwait", dwait, 1'b1);
        cyc(); ramstate = ACCESS; #2;
        chk("sim_ramWEN", ramWEN, 1'b1);
        chk("sim_ramREN", ramREN, 1'b0);
        chk("sim_ramaddr", ramaddr, 32'h80);
        chk("sim_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("sim_iwait_held", iwait, 1'b1);
        chk("sim_dwait_done", dwait, 1'b0);
        cyc(); dWEN = 1'b0; ramstate = FREE; #2;
        chk("sim_gap_ramREN", ramREN, 1'b0);
        chk("sim_gap_iwait", iwait, 1'b1);
        cyc(); ramstate = ACCESS; ramload = 32'h1111_2222; #2;
        chk("sim_i_ramREN", ramREN, 1'b1);
        chk("sim_i_ramaddr", ramaddr, 32'h44);
        chk("sim_i_iwait", iwait, 1'b0);
        chk("sim_i_iload", iload, 32'h1111_2222);
        cyc(); iREN = 1'b0; ramstate = FREE;

        // ERROR then retry of a data read
        cyc(); dREN = 1'b1; daddr = 32'h100;
        cyc(); ramstate = ERROR; #2;
        chk("err_ramREN", ramREN, 1'b1);
        chk("err_ramaddr", ramaddr, 32'h100);
        chk("err_dwait", dwait, 1'b1);
        cyc(); ramstate = FREE; #2;
        chk("err_idle_ramREN", ramREN, 1'b0);
        chk("err_idle_dwait", dwait, 1'b1);
        cyc(); ramstate = ACCESS; ramload = 32'h55; #2;
        chk("retry_ramREN", ramREN, 1'b1);
        chk("retry_ramaddr", ramaddr, 32'h100);
        chk("retry_dwait", dwait, 1'b0);
        chk("retry_dload", dload, 32'h55);
        cyc(); dREN = 1'b0; ramstate = FREE;

        // Withdrawal during BUSY
        cyc(); dREN = 1'b1; daddr = 32'h200;
        cyc(); ramstate = BUSY; #2;
        chk("wd_ramREN", ramREN, 1'b1);
        cyc(); dREN = 1'b0; #2;
        chk("wd_ramREN_drop", ramREN, 1'b0);
        chk("wd_dwait", dwait, 1'b0);
        cyc(); #2;
        chk("wd_idle_ramaddr", ramaddr, 32'h0);
        chk("wd_idle_ramREN", ramREN, 1'b0);

        // Continuous data reads with a waiting fetch
        cyc(); dREN = 1'b1; daddr = 32'h300; iREN = 1'b1; iaddr = 32'h400; ramstate = ACCESS;
        for (int c = 0; c < 20; c++) begin
            if (c != 0) cyc();
            #2;
            if (ramREN || ramWEN) grants.push_back(ramaddr);
        end
        chk("starve_grant_count", grants.size(), 10);
        for (int k = 0; k < grants.size(); k++) begin
            chk($sformatf("starve_grant%0d", k), grants[k],
                (FAIR && (k == 4 || k == 9)) ? 32'h400 : 32'h300);
        end

        cyc(); dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
